// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64I-subset control path.
// Used by the sequencer, its output decoder, ALU_Control and Control_unit.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       inst_read;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational map from sequencer state to the datapath strobe bundle.
// Zero latency; mem_ready only qualifies ir_write in FETCH and pc_write in MEM_WR.
module mc_out_decode
    import riscv_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.inst_read = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Unsupported opcode: skip to PC+4 without retiring
                ctrl_o.pc_write = !op_legal(opcode_i);
            end
            S_EXEC_R: begin
                ctrl_o.alu_op = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.alu_op  = ALU_FUNCT;
            end
            S_ALU_WB: begin
                // IR is stable for the whole instruction, so it recovers the EXEC operand select
                ctrl_o.alu_src   = (opcode_i == OP_IALU);
                ctrl_o.alu_op    = ALU_FUNCT;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.alu_op  = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.alu_op   = ALU_ADD;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.pc_write   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_BRANCH: begin
                ctrl_o.alu_op   = ALU_SUB;
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = zero_i;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer stepping each instruction through fetch/decode/exec/mem/write-back.
// 3-5 cycles per instruction; FETCH, MEM_RD and MEM_WR stall with requests held until mem_ready.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             inst_read,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    ctrl_t            ctrl, ctrl_g;
    logic             decode_illegal;

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign decode_illegal = (state_q == S_DECODE) && !op_legal(opcode);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_IALU:           state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Every legal instruction ends with exactly one pc_write; the DECODE skip is the only illegal one
    always_comb begin
        retired_d = retired_q;
        if (ctrl.pc_write && (state_q != S_DECODE)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        illegal_d = illegal_q | decode_illegal;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are forced low while reset is held so an abandoned instruction issues nothing
    assign ctrl_g     = reset ? ctrl : '0;

    assign pc_write   = ctrl_g.pc_write;
    assign pc_src     = ctrl_g.pc_src;
    assign ir_write   = ctrl_g.ir_write;
    assign inst_read  = ctrl_g.inst_read;
    assign mem_read   = ctrl_g.mem_read;
    assign mem_write  = ctrl_g.mem_write;
    assign reg_write  = ctrl_g.reg_write;
    assign mem_to_reg = ctrl_g.mem_to_reg;
    assign alu_src    = ctrl_g.alu_src;
    assign alu_op     = ctrl_g.alu_op;
    assign illegal    = illegal_q;
    assign retired    = retired_q;
    assign state      = state_q;

endmodule
